// File: rtl/sccb_cmd_arbiter_pkg.sv
// Shared types and constants for the SCCB command arbiter.
package sccb_pkg;

    typedef enum logic [2:0] {
        BOOT_FETCH,
        BOOT_SEND,
        BOOT_DELAY,
        GAP,
        RUN_IDLE,
        RUN_SEND
    } sccb_state_e;

    localparam logic [15:0] SCCB_DELAY_CODE     = 16'hFFF0;
    localparam logic [7:0]  SCCB_CAMERA_ID      = 8'h42;
    localparam int          SCCB_GAP_CYCLES     = 256;
    localparam int          SCCB_DELAY_CYCLES   = 500000;
    localparam int          SCCB_TIMEOUT_CYCLES = 65535;

    // Largest of three lengths; sizes the shared down counter.
    function automatic int sccb_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sccb_cmd_arbiter_down_counter.sv
// Loadable down counter with zero flag; one instance serves delay, gap
// and watchdog timing since only one of them is ever running.
module sccb_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load wins over enable; counting stops at zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= value_i;
        else if (en_i && cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Arbitrates the single SCCB sender between the boot ROM stream and the
// runtime register-write port. Optional send watchdog: SCCB_TIMEOUT_EN.
module sccb_cmd_arbiter
    import sccb_pkg::*;
#(
    parameter int          GAP_CYCLES     = SCCB_GAP_CYCLES,
    parameter int          DELAY_CYCLES   = SCCB_DELAY_CYCLES,
    parameter logic [15:0] DELAY_CODE     = SCCB_DELAY_CODE,
    parameter int          TIMEOUT_CYCLES = SCCB_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] rom_command,
    input  logic        rom_finished,
    output logic        rom_advance,
    input  logic        rt_req,
    input  logic [7:0]  rt_regi,
    input  logic [7:0]  rt_value,
    output logic        rt_ack,
    output logic        i2c_send,
    output logic [7:0]  i2c_regi,
    output logic [7:0]  i2c_value,
    input  logic        i2c_taken,
    output logic        config_finished,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(sccb_max3(DELAY_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LD = CW'(DELAY_CYCLES - 1);
`ifdef SCCB_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LD    = CW'(TIMEOUT_CYCLES - 1);
`endif

    sccb_state_e   state_q;
    logic          adv_q, ack_q, send_q, cfg_q, busy_q;
    logic [7:0]    regi_q, value_q;
    logic          cnt_load, cnt_en, cnt_zero;
    logic [CW-1:0] cnt_val;
    logic          timed_out, send_done;

    sccb_down_counter #(.W(CW)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (cnt_load),
        .value_i (cnt_val),
        .en_i    (cnt_en),
        .zero_o  (cnt_zero)
    );

`ifdef SCCB_TIMEOUT_EN
    logic timeout_q;
    logic in_send;
    assign in_send   = (state_q == BOOT_SEND) || (state_q == RUN_SEND);
    assign timed_out = in_send && cnt_zero && !i2c_taken;

    // Sticky watchdog flag; a timed-out send is otherwise treated as taken.
    always_ff @(posedge clk) begin
        if (!rst_n)
            timeout_q <= 1'b0;
        else if (timed_out)
            timeout_q <= 1'b1;
    end
    assign timeout_err = timeout_q;
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign send_done = i2c_taken || timed_out;

    // Counter control: load on entry to a timed state, count while in it.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
        case (state_q)
            BOOT_FETCH: begin
                if (!rom_finished && rom_command == DELAY_CODE) begin
                    cnt_load = 1'b1;
                    cnt_val  = DELAY_LD;
                end
`ifdef SCCB_TIMEOUT_EN
                else if (!rom_finished) begin
                    cnt_load = 1'b1;
                    cnt_val  = TO_LD;
                end
`endif
            end
            BOOT_SEND, RUN_SEND: begin
                if (send_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = GAP_LD;
                end
`ifdef SCCB_TIMEOUT_EN
                else cnt_en = 1'b1;
`endif
            end
            BOOT_DELAY, GAP: cnt_en = 1'b1;
            RUN_IDLE: begin
`ifdef SCCB_TIMEOUT_EN
                if (rt_req) begin
                    cnt_load = 1'b1;
                    cnt_val  = TO_LD;
                end
`endif
            end
            default: ;
        endcase
    end

    // Main sequencer with registered outputs; busy tracks every move
    // into or out of RUN_IDLE so it is itself a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT_FETCH;
            adv_q   <= 1'b0;
            ack_q   <= 1'b0;
            send_q  <= 1'b0;
            cfg_q   <= 1'b0;
            busy_q  <= 1'b1;
            regi_q  <= '0;
            value_q <= '0;
        end else begin
            adv_q <= 1'b0;
            ack_q <= 1'b0;
            case (state_q)
                BOOT_FETCH: begin
                    if (rom_finished) begin
                        cfg_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= RUN_IDLE;
                    end else if (rom_command == DELAY_CODE) begin
                        adv_q   <= 1'b1;
                        state_q <= BOOT_DELAY;
                    end else begin
                        regi_q  <= rom_command[15:8];
                        value_q <= rom_command[7:0];
                        send_q  <= 1'b1;
                        state_q <= BOOT_SEND;
                    end
                end
                BOOT_SEND: if (send_done) begin
                    send_q  <= 1'b0;
                    adv_q   <= 1'b1;
                    state_q <= GAP;
                end
                BOOT_DELAY: if (cnt_zero) state_q <= BOOT_FETCH;
                GAP: if (cnt_zero) begin
                    if (cfg_q) begin
                        busy_q  <= 1'b0;
                        state_q <= RUN_IDLE;
                    end else begin
                        state_q <= BOOT_FETCH;
                    end
                end
                RUN_IDLE: if (rt_req) begin
                    regi_q  <= rt_regi;
                    value_q <= rt_value;
                    send_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= RUN_SEND;
                end
                RUN_SEND: if (send_done) begin
                    send_q  <= 1'b0;
                    ack_q   <= 1'b1;
                    state_q <= GAP;
                end
                default: state_q <= BOOT_FETCH;
            endcase
        end
    end

    assign rom_advance     = adv_q;
    assign rt_ack          = ack_q;
    assign i2c_send        = send_q;
    assign i2c_regi        = regi_q;
    assign i2c_value       = value_q;
    assign config_finished = cfg_q;
    assign busy            = busy_q;

endmodule

// File: doc/sccb_cmd_arbiter.md
Name: sccb_cmd_arbiter

Overview:
Sequences and shares the single SCCB/I2C sender between two command sources.
- Boot-time register ROM stream: exclusive owner until the ROM reports finished.
- Runtime single-register write port, e.g. exposure/gain tweaks from the CNN side.

Also interprets the ROM delay code as a wait, enforces an inter-command gap, and raises config_finished once boot configuration is complete.

Parameters:
GAP_CYCLES, 256, idle clk cycles between sender acceptance and next issue (>=1)
DELAY_CYCLES, 500000, wait length for a ROM delay entry (10 ms at 50 MHz)
DELAY_CODE, 16'hFFF0, ROM command value meaning "wait DELAY_CYCLES, send nothing"
TIMEOUT_CYCLES, 65535, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rom_command  in  16  current ROM entry {regi, value}
rom_finished  in  1  ROM exhausted
rom_advance  out  1  1-cycle pulse: step ROM to next entry
rt_req  in  1  runtime write request, level, held until rt_ack
rt_regi  in  8  runtime register address, stable while rt_req
rt_value  in  8  runtime register data, stable while rt_req
rt_ack  out  1  1-cycle pulse: runtime write accepted by sender
i2c_send  out  1  request to sender, level
i2c_regi  out  8  register address to sender
i2c_value  out  8  data to sender
i2c_taken  in  1  sender accepted current command
config_finished  out  1  boot configuration done, sticky until reset
busy  out  1  high whenever state != RUN_IDLE
timeout_err  out  1  sticky watchdog flag (0 without the optional feature)

Behaviour:
Clocking and reset:
- All outputs are registered; synchronous reset on clk when rst_n=0.
- Reset values: state=BOOT_FETCH; rom_advance, rt_ack, i2c_send, config_finished, timeout_err = 0; i2c_regi, i2c_value = 0.

State transitions:
- BOOT_FETCH:
  - rom_finished=1 -> config_finished<=1, go RUN_IDLE.
  - Else rom_command==DELAY_CODE (full 16-bit compare) -> rom_advance pulse, load counter DELAY_CYCLES-1, go BOOT_DELAY.
  - Else latch rom_command into i2c_regi/i2c_value, i2c_send<=1, go BOOT_SEND.
- BOOT_SEND:
  - Hold i2c_send and data.
  - On i2c_taken=1: i2c_send<=0 on that same edge, rom_advance pulse, load counter GAP_CYCLES-1, go GAP.
- BOOT_DELAY: count down; at 0 go BOOT_FETCH. The ROM has already advanced.
- GAP: count down; at 0 go BOOT_FETCH if config_finished=0, else RUN_IDLE.
- RUN_IDLE:
  - rt_req=1 -> latch rt_regi/rt_value, i2c_send<=1, go RUN_SEND.
- RUN_SEND:
  - On i2c_taken: i2c_send<=0, rt_ack pulse, load gap counter, go GAP.

Handshake and timing rules:
- i2c_send never stays high in the cycle after i2c_taken is sampled, so there is no double issue.
- i2c_taken outside a SEND state is ignored.
- rt_req during boot is not acknowledged; it is served in the first RUN_IDLE after config_finished.
- rt_req re-asserted in the cycle after rt_ack starts a new write only after GAP completes.
- ROM output settles the cycle after rom_advance. GAP and BOOT_DELAY are each >=1 cycle, so BOOT_FETCH always sees the new entry.
- Latency: rt_req rising in RUN_IDLE -> i2c_send high 1 cycle later.

Counter and arithmetic rules:
- One shared down counter, width $clog2(max(DELAY_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1).
- GAP_CYCLES=1 gives exactly one GAP cycle.

Reset mid-operation:
- Abandons the transfer and drops i2c_send next edge.
- Clears config_finished; boot restarts from BOOT_FETCH. The ROM shares rst_n, so it returns to entry 0.
- A pending runtime request is not lost; the requester still holds it.

Optional Feature:
SCCB_TIMEOUT_EN
- Defined: in BOOT_SEND/RUN_SEND the counter counts from TIMEOUT_CYCLES-1. On reaching 0 without i2c_taken:
  - Drop i2c_send and set timeout_err (sticky).
  - Proceed exactly as if taken: rom_advance or rt_ack pulse, then GAP.
- Undefined: SEND waits indefinitely; timeout_err is tied 0; no timeout logic is synthesized.

Decomposition:
- Package sccb_pkg holds:
  - state enum (BOOT_FETCH, BOOT_SEND, BOOT_DELAY, GAP, RUN_IDLE, RUN_SEND);
  - SCCB_DELAY_CODE=16'hFFF0;
  - SCCB_CAMERA_ID=8'h42;
  - default GAP/DELAY constants.
- One sub-module: sccb_down_counter. Parameterized width, load/value/enable, zero flag; shared by delay, gap and timeout.

Test Plan:
All scenarios use GAP_CYCLES=4, DELAY_CYCLES=20.
1. ROM {16'h1280, 16'h1101, finished}, sender asserts taken 3 cycles after send -> two sends with regi/value 12/80 then 11/01, each followed by exactly 4 GAP cycles; 2 rom_advance pulses; then config_finished=1, busy=0.
2. ROM {16'hFFF0, 16'h3A04, finished} -> rom_advance, no i2c_send for 20 cycles, then send 3A/04.
3. rt_req=1, rt_regi=8'h10, rt_value=8'h40 asserted at reset release -> no rt_ack before config_finished; single send 10/40 afterwards, one rt_ack pulse.
4. Taken held high 2 cycles -> only one transfer, one rom_advance.
5. rst_n=0 for 1 cycle during BOOT_SEND of entry 2 -> i2c_send=0, config_finished=0 next cycle; boot replays from entry 0.
6. With SCCB_TIMEOUT_EN, TIMEOUT_CYCLES=50, taken never asserted -> i2c_send drops after 50 cycles, timeout_err=1, rom_advance pulses, boot continues.
